zeroriscy_multdiv_iter: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU.

---
 rtl/zeroriscy_defines.sv | 40 ++++
 rtl/zeroriscy_multdiv_iter.sv | 174 +++++++++++++++++
 tb/tb_zeroriscy_multdiv_iter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_defines.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package zeroriscy_defines;

    typedef enum logic [2:0] {
        MD_OP_MUL    = 3'b000,
        MD_OP_MULH   = 3'b001,
        MD_OP_MULHSU = 3'b010,
        MD_OP_MULHU  = 3'b011,
        MD_OP_DIV    = 3'b100,
        MD_OP_DIVU   = 3'b101,
        MD_OP_REM    = 3'b110,
        MD_OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_ABS_A,
        MD_ABS_B,
        MD_ITER,
        MD_FIX_LO,
        MD_FIX_HI,
        MD_DONE
    } md_state_e;

    localparam int unsigned MD_ITERATIONS = 32;
    localparam logic [4:0]  MD_ITER_LAST  = 5'(MD_ITERATIONS - 1);

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic md_signed_a(input md_op_e op);
        return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
    endfunction

    function automatic logic md_signed_b(input md_op_e op);
        return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
    endfunction

endpackage

// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative 1-bit/cycle RV32M multiply/divide; borrows the ALU adder every busy cycle.
module zeroriscy_multdiv_iter
    import zeroriscy_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        kill_i,
    input  logic [2:0]  operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        alu_en_o,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    input  logic [33:0] alu_adder_ext_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    md_state_e   state_q;
    md_op_e      op_q;
    logic [31:0] op_a_q;      // multiplicand, or dividend shifted left each step
    logic [31:0] op_b_q;      // multiplier shifted right each step, or divisor
    logic [31:0] acc_hi_q;    // product high word, or partial remainder
    logic [31:0] acc_lo_q;    // product low word, or quotient
    logic [31:0] result_q;
    logic [4:0]  cnt_q;
    logic        neg_a_q, neg_b_q, neg_lo_q, neg_hi_q, lo_zero_q;

    md_op_e      op_in;
    logic        sa_in, sb_in, div0_in;
    logic        is_div, hi_cin, div_ok;
    logic [32:0] div_p;
    logic [31:0] sum;
    logic        carry;
    logic [31:0] hi_next;
    logic        unused_sum_lsb;

    assign op_in   = md_op_e'(operator_i);
    assign sa_in   = md_signed_a(op_in) & op_a_i[31];
    assign sb_in   = md_signed_b(op_in) & op_b_i[31];
    assign div0_in = (op_b_i == 32'b0);

    assign is_div  = md_is_div(op_q);
    assign div_p   = {acc_hi_q, op_a_q[31]};
    // Multiply negation borrows from the low word; a lone remainder negates with a plain +1.
    assign hi_cin  = is_div | lo_zero_q;

    assign sum            = alu_adder_ext_i[32:1];
    assign carry          = alu_adder_ext_i[33];
    assign unused_sum_lsb = alu_adder_ext_i[0];
    assign div_ok         = div_p[32] | carry;
    assign hi_next        = neg_hi_q ? sum : acc_hi_q;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        alu_en_o        = 1'b0;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        unique case (state_q)
            MD_ABS_A: begin
                alu_en_o        = 1'b1;
                alu_operand_a_o = {~op_a_q, 1'b1};
                alu_operand_b_o = {32'b0, 1'b1};
            end
            MD_ABS_B: begin
                alu_en_o        = 1'b1;
                alu_operand_a_o = {~op_b_q, 1'b1};
                alu_operand_b_o = {32'b0, 1'b1};
            end
            MD_ITER: begin
                alu_en_o = 1'b1;
                if (is_div) begin
                    alu_operand_a_o = {div_p[31:0], 1'b1};
                    alu_operand_b_o = {~op_b_q, 1'b1};
                end else begin
                    alu_operand_a_o = {acc_hi_q, 1'b0};
                    alu_operand_b_o = {(op_b_q[0] ? op_a_q : 32'b0), 1'b0};
                end
            end
            MD_FIX_LO: begin
                alu_en_o        = 1'b1;
                alu_operand_a_o = {~acc_lo_q, 1'b1};
                alu_operand_b_o = {32'b0, 1'b1};
            end
            MD_FIX_HI: begin
                alu_en_o        = 1'b1;
                alu_operand_a_o = {~acc_hi_q, hi_cin};
                alu_operand_b_o = {32'b0, hi_cin};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_OP_MUL;
            op_a_q    <= '0;
            op_b_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            lo_zero_q <= 1'b0;
        end else if (kill_i) begin
            state_q <= MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: if (en_i) begin
                    state_q  <= MD_ABS_A;
                    op_q     <= op_in;
                    op_a_q   <= op_a_i;
                    op_b_q   <= op_b_i;
                    acc_hi_q <= '0;
                    acc_lo_q <= '0;
                    neg_a_q  <= sa_in;
                    neg_b_q  <= sb_in;
                    // Divide by zero keeps the all-ones quotient but still signs the remainder.
                    neg_lo_q <= (sa_in ^ sb_in) & ~(md_is_div(op_in) & div0_in);
                    neg_hi_q <= md_is_div(op_in) ? sa_in : (sa_in ^ sb_in);
                end
                MD_ABS_A: begin
                    if (neg_a_q) op_a_q <= sum;
                    state_q <= MD_ABS_B;
                end
                MD_ABS_B: begin
                    if (neg_b_q) op_b_q <= sum;
                    cnt_q   <= MD_ITER_LAST;
                    state_q <= MD_ITER;
                end
                MD_ITER: begin
                    if (is_div) begin
                        acc_hi_q <= div_ok ? sum : div_p[31:0];
                        acc_lo_q <= {acc_lo_q[30:0], div_ok};
                        op_a_q   <= {op_a_q[30:0], 1'b0};
                    end else begin
                        acc_hi_q <= {carry, sum[31:1]};
                        acc_lo_q <= {sum[0], acc_lo_q[31:1]};
                        op_b_q   <= {1'b0, op_b_q[31:1]};
                    end
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) state_q <= MD_FIX_LO;
                end
                MD_FIX_LO: begin
                    lo_zero_q <= (acc_lo_q == 32'b0);
                    if (neg_lo_q) acc_lo_q <= sum;
                    state_q <= MD_FIX_HI;
                end
                MD_FIX_HI: begin
                    acc_hi_q <= hi_next;
                    unique case (op_q)
                        MD_OP_MUL, MD_OP_DIV, MD_OP_DIVU: result_q <= acc_lo_q;
                        default:                          result_q <= hi_next;
                    endcase
                    state_q <= MD_DONE;
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_iter.sv
// Directed bench for the iterative multiply/divide unit with a behavioural ALU adder.
module tb_zeroriscy_multdiv_iter;
    import zeroriscy_defines::*;

    localparam int LATENCY = 37;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i, kill_i;
    logic [2:0]  operator_i;
    logic [31:0] op_a_i, op_b_i;
    logic        alu_en_o;
    logic [32:0] alu_operand_a_o, alu_operand_b_o;
    logic [33:0] alu_adder_ext_i;
    logic        ready_o, valid_o;
    logic [31:0] result_o;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign alu_adder_ext_i = {1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o};

    zeroriscy_multdiv_iter dut (
        .clk             (clk),
        .rst             (rst),
        .en_i            (en_i),
        .kill_i          (kill_i),
        .operator_i      (operator_i),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .alu_en_o        (alu_en_o),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .alu_adder_ext_i (alu_adder_ext_i),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .result_o        (result_o)
    );

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after DONE.
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name, input bit pulse_en);
        int n;
        bit busy_ok;
        check({name, " ready_before"}, 64'(ready_o), 64'd1);
        en_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b;
        @(negedge clk);
        en_i = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!valid_o && n < LATENCY + 10) begin
            if (ready_o) busy_ok = 1'b0;
            en_i = pulse_en && (n % 4 == 0) && (n < 34);
            if (pulse_en) begin
                operator_i = MD_OP_DIVU; op_a_i = 32'h1234_5678; op_b_i = 32'h0;
            end
            @(negedge clk);
            n++;
        end
        en_i = 1'b0;
        check({name, " latency"}, 64'(n), 64'(LATENCY));
        check({name, " ready_low"}, 64'(busy_ok), 64'd1);
        check({name, " result"}, 64'(result_o), 64'(exp));
        @(negedge clk);
        check({name, " valid_pulse"}, 64'({valid_o, ready_o}), 64'b01);
        check({name, " hold"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        int n;
        bit seen_valid;

        vecs[0]  = '{MD_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
        vecs[1]  = '{MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min"};
        vecs[2]  = '{MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
        vecs[3]  = '{MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max"};
        vecs[4]  = '{MD_OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[5]  = '{MD_OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2"};
        vecs[6]  = '{MD_OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, "divu_max_1"};
        vecs[7]  = '{MD_OP_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, "div_m5_0"};
        vecs[8]  = '{MD_OP_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, "rem_m5_0"};
        vecs[9]  = '{MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        vecs[10] = '{MD_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"};
        vecs[11] = '{MD_OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, "divu_100_7"};
        vecs[12] = '{MD_OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "remu_100_7"};
        vecs[13] = '{MD_OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "mulh_m2_3"};
        vecs[14] = '{MD_OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_5_0"};
        vecs[15] = '{MD_OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2"};
        vecs[16] = '{MD_OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"};

        rst = 1'b1; en_i = 1'b0; kill_i = 1'b0;
        operator_i = 3'b000; op_a_i = '0; op_b_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst ready", 64'(ready_o), 64'd1);
        check("rst valid", 64'(valid_o), 64'd0);
        check("rst result", 64'(result_o), 64'd0);
        check("rst alu_en", 64'(alu_en_o), 64'd0);
        check("rst operands", {alu_operand_a_o, alu_operand_b_o}, 64'd0);

        for (int i = 0; i < 17; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b0);

        // Kill a divide in flight.
        en_i = 1'b1; operator_i = MD_OP_DIV; op_a_i = 32'd1000; op_b_i = 32'd3;
        @(negedge clk);
        en_i = 1'b0;
        n = 1;
        seen_valid = 1'b0;
        while (n < 10) begin
            if (valid_o) seen_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        check("kill busy_alu_en", 64'(alu_en_o), 64'd1);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill ready", 64'(ready_o), 64'd1);
        check("kill no_valid", 64'({seen_valid, valid_o}), 64'd0);

        // en_i together with kill_i in IDLE is not accepted.
        en_i = 1'b1; kill_i = 1'b1; operator_i = MD_OP_MUL; op_a_i = 32'd9; op_b_i = 32'd9;
        @(negedge clk);
        en_i = 1'b0; kill_i = 1'b0;
        check("kill_en idle", 64'({ready_o, alu_en_o}), 64'b10);

        run_op(MD_OP_MUL, 32'd3, 32'd5, 32'd15, "mul_after_kill", 1'b1);

        // Reset in the middle of an operation.
        en_i = 1'b1; operator_i = MD_OP_MUL; op_a_i = 32'd11; op_b_i = 32'd13;
        @(negedge clk);
        en_i = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst ready", 64'(ready_o), 64'd1);
        check("midrst valid", 64'(valid_o), 64'd0);
        check("midrst result", 64'(result_o), 64'd0);
        check("midrst alu_en", 64'(alu_en_o), 64'd0);

        run_op(MD_OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "mulhu_after_rst", 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
